fetch_queue: RTL



---
 rtl/fetch_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, tags returned words with their PC,
// buffers them in a DEPTH-entry FIFO and hands them to decode over valid/ready.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [14:0] RESET_PC = 15'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [14:0]                  mem_raddr,
    input  logic [15:0]                  mem_rdata,
    input  logic                         redirect,
    input  logic [14:0]                  redirect_pc,
    input  logic                         halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_inst,
    output logic [14:0]                  out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    logic [14:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [14:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   inst_q [DEPTH];
    logic [14:0]   pc_q   [DEPTH];

    logic [CW:0]   credit_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;

    assign mem_raddr = fetch_pc_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_inst  = inst_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];

    // Handshake decode and next-state for fetch pointer, in-flight tracker and FIFO bookkeeping
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        // The in-flight word already holds a FIFO slot, so it counts against the credit.
        credit_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue_s  = ~rst & ~redirect & ~halt & (credit_s < DEPTH_C);
        push_s   = inflight_q & ~redirect;
        pop_s    = out_valid & out_ready & ~redirect;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue_s) begin
                fetch_pc_d    = fetch_pc_q + 15'd1;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                inflight_d = 1'b0;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 15'h0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= 16'h0;
                pc_q[i]   <= 15'h0;
            end
        end else if (push_s) begin
            inst_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end else begin
            inst_q[wr_ptr_q] <= inst_q[wr_ptr_q];
            pc_q[wr_ptr_q]   <= pc_q[wr_ptr_q];
        end
    end

endmodule
